// File: rtl/dmem_arb_pkg.sv
// Shared types and defaults for the data memory arbiter.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_DBG = 1'b1;

    localparam logic [31:0] DEF_BASE_ADDR = 32'h1001_0000;
    localparam int          DEF_DEPTH     = 64;

    // 33-bit compare so base + 4*depth cannot wrap at the top of the address space
    function automatic logic addr_legal(input logic [31:0] addr,
                                        input logic [31:0] base,
                                        input int unsigned depth);
        logic [32:0] a;
        logic [32:0] lo;
        logic [32:0] hi;
        a  = {1'b0, addr};
        lo = {1'b0, base};
        hi = lo + (33'(depth) << 2);
        return (a >= lo) && (a < hi) && (addr[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/data_memory_arbiter_if.sv
// Request/response and memory-side bundle of the data memory arbiter.
interface dmem_arb_if;
    logic        req0_valid;
    logic        req0_write;
    logic [31:0] req0_addr;
    logic [31:0] req0_wdata;
    logic        req0_ready;
    logic        rsp0_valid;
    logic [31:0] rsp0_rdata;
    logic        rsp0_err;

    logic        req1_valid;
    logic        req1_write;
    logic [31:0] req1_addr;
    logic [31:0] req1_wdata;
    logic        req1_ready;
    logic        rsp1_valid;
    logic [31:0] rsp1_rdata;
    logic        rsp1_err;

    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    modport slave (
        input  req0_valid, req0_write, req0_addr, req0_wdata,
        output req0_ready, rsp0_valid, rsp0_rdata, rsp0_err,
        input  req1_valid, req1_write, req1_addr, req1_wdata,
        output req1_ready, rsp1_valid, rsp1_rdata, rsp1_err,
        output mem_read, mem_write, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output req0_valid, req0_write, req0_addr, req0_wdata,
        input  req0_ready, rsp0_valid, rsp0_rdata, rsp0_err,
        output req1_valid, req1_write, req1_addr, req1_wdata,
        input  req1_ready, rsp1_valid, rsp1_rdata, rsp1_err,
        input  mem_read, mem_write, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant: on contention the port that did not win last time wins.
module rr_arbiter2
    import dmem_arb_pkg::*;
(
    input  logic [1:0] valid,
    input  logic       last_grant,
    output logic [1:0] grant,
    output logic       grant_id
);

    always_comb begin
        grant_id = PORT_CPU;
        if (valid[0] && valid[1]) begin
            grant_id = ~last_grant;
        end else if (valid[1]) begin
            grant_id = PORT_DBG;
        end
        grant = 2'b00;
        if (valid != 2'b00) begin
            grant = grant_id ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/data_memory_arbiter.sv
// Shares the single-port data memory between the MEM stage (port 0) and the debug port (port 1).
//   state  | meaning
//   IDLE   | no access in flight, may accept
//   ACCESS | memory strobe cycle for the captured request
//   RESP   | response to the captured port, may accept the next request
module data_memory_arbiter
    import dmem_arb_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = DEF_BASE_ADDR,
    parameter int          DEPTH     = DEF_DEPTH
) (
    input  logic       clk,
    input  logic       reset,
    dmem_arb_if.slave  bus
);

    state_t      state_q, state_d;
    logic        last_grant_q;
    logic [1:0]  gnt;
    logic        gnt_id;
    logic        accept_en;
    logic        hs;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;

    logic        cap_port;
    logic        cap_write;
    logic [31:0] cap_addr;
    logic [31:0] cap_wdata;
    logic        cap_legal;
    logic [31:0] rdata_q;

    logic        mem_read_c, mem_write_c;
    logic        rsp0_valid_c, rsp1_valid_c;

    rr_arbiter2 u_arb (
        .valid      ({bus.req1_valid, bus.req0_valid}),
        .last_grant (last_grant_q),
        .grant      (gnt),
        .grant_id   (gnt_id)
    );

    assign accept_en      = (state_q == IDLE) || (state_q == RESP);
    assign bus.req0_ready = accept_en & gnt[0];
    assign bus.req1_ready = accept_en & gnt[1];
    assign hs             = bus.req0_ready | bus.req1_ready;

    assign req_write = gnt_id ? bus.req1_write : bus.req0_write;
    assign req_addr  = gnt_id ? bus.req1_addr  : bus.req0_addr;
    assign req_wdata = gnt_id ? bus.req1_wdata : bus.req0_wdata;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            last_grant_q <= PORT_DBG;
            cap_port     <= PORT_CPU;
            cap_write    <= 1'b0;
            cap_addr     <= '0;
            cap_wdata    <= '0;
            cap_legal    <= 1'b0;
            rdata_q      <= '0;
        end else begin
            state_q <= state_d;
            if (hs) begin
                last_grant_q <= gnt_id;
                cap_port     <= gnt_id;
                cap_write    <= req_write;
                cap_addr     <= req_addr;
                cap_wdata    <= req_wdata;
                cap_legal    <= addr_legal(req_addr, BASE_ADDR, DEPTH);
            end
            if (state_q == ACCESS) begin
                rdata_q <= (cap_legal && !cap_write) ? bus.mem_rdata : 32'h0;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        mem_read_c   = 1'b0;
        mem_write_c  = 1'b0;
        rsp0_valid_c = 1'b0;
        rsp1_valid_c = 1'b0;
        case (state_q)
            IDLE: begin
                if (hs) state_d = ACCESS;
            end
            ACCESS: begin
                mem_read_c  = cap_legal & ~cap_write;
                mem_write_c = cap_legal & cap_write;
                state_d     = RESP;
            end
            RESP: begin
                rsp0_valid_c = (cap_port == PORT_CPU);
                rsp1_valid_c = (cap_port == PORT_DBG);
                state_d      = hs ? ACCESS : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Address and data simply follow the capture registers, so they hold between accesses
    assign bus.mem_read   = mem_read_c;
    assign bus.mem_write  = mem_write_c;
    assign bus.mem_addr   = cap_addr;
    assign bus.mem_wdata  = cap_wdata;

    assign bus.rsp0_valid = rsp0_valid_c;
    assign bus.rsp0_rdata = rsp0_valid_c ? rdata_q : 32'h0;
    assign bus.rsp0_err   = rsp0_valid_c & ~cap_legal;
    assign bus.rsp1_valid = rsp1_valid_c;
    assign bus.rsp1_rdata = rsp1_valid_c ? rdata_q : 32'h0;
    assign bus.rsp1_err   = rsp1_valid_c & ~cap_legal;

endmodule
